cr_tlvp_ob_merge: RTL
=====================

CR_TLVP_OB_MERGE -- requirements
Module: cr_tlvp_ob_merge

Interface
REQ-001 SHALL have parameter N_ORDER_ENTRIES, default 8, the depth of the internal TLV-order queue (power of 2, 4..32).
REQ-002 SHALL have a single clock and an asynchronous, active-low reset:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have the passthrough TLV source:
- pt_ob_empty  input  1  passthrough FIFO empty.
- pt_ob_tlv  input  tlvp_if_bus_t  passthrough FIFO head beat.
- pt_ob_rd  output  1  passthrough FIFO pop.
REQ-004 SHALL have the user TLV source:
- usr_ob_empty  input  1  user FIFO empty.
- usr_ob_tlv  input  tlvp_if_bus_t  user FIFO head beat.
- usr_ob_rd  output  1  user FIFO pop.
REQ-005 SHALL have the order interface:
- order_wen  input  1  push one order entry.
- order_sel  input  1  source of the next TLV (0 = passthrough, 1 = user).
- order_full  output  1  order queue full.
REQ-006 SHALL have the merged output and error ports:
- tlvp_ob_wr  output  1  output beat valid.
- tlvp_ob  output  axi4s_dp_bus_t  output beat.
- tlvp_ob_full  input  1  downstream full.
- tlvp_ob_afull  input  1  downstream has one or fewer free slots.
- tlvp_error  output  1  sticky protocol error.

Function
REQ-007 SHALL implement the order queue as an N_ORDER_ENTRIES-deep FIFO with wrap-around pointers, and drive order_full when the occupancy equals N_ORDER_ENTRIES.
REQ-008 SHALL drop an order_wen that arrives while order_full is set (occupancy unchanged) and set tlvp_error.
REQ-009 SHALL accept a push and a pop in the same cycle when the queue is full (the pop frees the slot), with occupancy unchanged.
REQ-010 SHALL use a 3-state FSM with states IDLE, PT and USR.
- IDLE: when the order queue is non-empty, pop the head and go to PT (sel=0) or USR (sel=1). No source read occurs in this cycle.
REQ-011 SHALL, in PT or USR, issue rd on the selected source only when that source is non-empty and tlvp_ob_afull=0. The non-selected source's rd SHALL be 0.
REQ-012 SHALL end the TLV on a read beat with eot=1, and then:
- if the order queue is non-empty, pop it in the same cycle and enter PT/USR directly (no bubble);
- otherwise go to IDLE.
REQ-013 SHALL register the output one cycle after the source read: tlvp_ob_wr=1, and tlvp_ob.tvalid=1. tdata, tstrb, tuser, tid and tlast SHALL copy the read beat; all other tlvp_if_bus_t fields are discarded.
REQ-014 SHALL hold tlvp_ob_wr=0 with tlvp_ob unchanged in cycles without a read.
REQ-015 SHALL sustain one beat per cycle while the source is non-empty and tlvp_ob_afull=0.
REQ-016 SHALL, when a beat with sot=1 is read after the first beat of a TLV, set tlvp_error and still forward the beat.
REQ-017 SHALL, when the first beat of a TLV has sot=0, set tlvp_error and still forward the beat.
REQ-018 SHALL keep tlvp_error set until reset.
REQ-019 SHALL never assert tlvp_ob_wr while tlvp_ob_full=1 given a compliant downstream (afull threshold at least 1). A write while full is a downstream fault and is not checked here.

Reset
REQ-020 SHALL, while rst_n=0, set the FSM to IDLE, empty the order queue, and hold all outputs at 0: pt_ob_rd, usr_ob_rd, tlvp_ob_wr, tlvp_ob, tlvp_error, order_full.
REQ-021 SHALL, on assertion of rst_n=0 mid-TLV, abandon the partial TLV with no further reads or writes. The order entries are lost.
REQ-022 SHALL apply no reads in the first cycle after reset release.

Verification
REQ-023 SHALL pass: push sel=0, then sel=1; pt holds a 3-beat TLV and usr holds a 2-beat TLV -> 5 output beats in order pt0, pt1, pt2, usr0, usr1, with no bubble between pt2 and usr0.
REQ-024 SHALL pass: tlvp_ob_afull held at 1 for 4 cycles mid-TLV -> no rd and no wr during the stall; beat order preserved after release.
REQ-025 SHALL pass: 9 pushes with N_ORDER_ENTRIES=8 and no pops -> order_full=1 after the 8th push; the 9th is dropped; tlvp_error=1.
REQ-026 SHALL pass: usr TLV whose second beat has sot=1 -> tlvp_error=1 and the beat is still output.
REQ-027 SHALL pass: rst_n pulsed low during beat 2 of a 4-beat TLV -> all outputs 0; after release, FSM in IDLE and order_full=0.
REQ-028 SHALL pass: order queue empty while both sources are non-empty -> pt_ob_rd=0, usr_ob_rd=0, tlvp_ob_wr=0.

Source files
------------

// File: rtl/cr_tlvp_ob_merge_pkg.sv
// cr_tlvp_ob_merge_pkg: beat formats for the TLV source FIFOs and the merged AXI4-S output.
package cr_tlvp_ob_merge_pkg;
   typedef struct packed {
      logic        sot;
      logic        eot;
      logic        tlast;
      logic [1:0]  tid;
      logic [7:0]  tuser;
      logic [7:0]  tstrb;
      logic [63:0] tdata;
   } tlvp_if_bus_t;
   typedef struct packed {
      logic        tvalid;
      logic        tlast;
      logic [1:0]  tid;
      logic [7:0]  tuser;
      logic [7:0]  tstrb;
      logic [63:0] tdata;
   } axi4s_dp_bus_t;
endpackage

// File: rtl/cr_tlvp_ob_merge.sv
// cr_tlvp_ob_merge: merges passthrough and user TLVs onto one output stream in the order given by a small order queue.
module cr_tlvp_ob_merge
   import cr_tlvp_ob_merge_pkg::*;
#(
   parameter int N_ORDER_ENTRIES = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pt_ob_empty,
   input  tlvp_if_bus_t  pt_ob_tlv,
   output logic          pt_ob_rd,
   input  logic          usr_ob_empty,
   input  tlvp_if_bus_t  usr_ob_tlv,
   output logic          usr_ob_rd,
   input  logic          order_wen,
   input  logic          order_sel,
   output logic          order_full,
   output logic          tlvp_ob_wr,
   output axi4s_dp_bus_t tlvp_ob,
   input  logic          tlvp_ob_full,
   input  logic          tlvp_ob_afull,
   output logic          tlvp_error
);
   localparam int AW = $clog2(N_ORDER_ENTRIES);
   typedef enum logic [1:0] {IDLE, PT, USR} state_t;
   state_t                     state_q, state_d;
   logic [N_ORDER_ENTRIES-1:0] sel_q;
   logic [AW:0]                wp_q, rp_q;
   logic                       first_q, first_d, err_q, err_d, wr_q;
   axi4s_dp_bus_t              ob_q, ob_d;
   tlvp_if_bus_t               beat;
   logic                       empty, push, pop, rd, done, src_empty;
   assign empty      = wp_q == rp_q;
   assign order_full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
   assign tlvp_ob_wr = wr_q;
   assign tlvp_ob    = ob_q;
   assign tlvp_error = err_q;
   always_comb begin
      beat      = (state_q == USR) ? usr_ob_tlv : pt_ob_tlv;
      src_empty = (state_q == USR) ? usr_ob_empty : pt_ob_empty;
      rd        = (state_q != IDLE) && !src_empty && !tlvp_ob_afull && !tlvp_ob_full;
      pt_ob_rd  = rd && (state_q == PT);
      usr_ob_rd = rd && (state_q == USR);
      done      = (state_q == IDLE) || (rd && beat.eot);
      pop       = done && !empty;
      push      = order_wen && (!order_full || pop);
      state_d   = !done ? state_q : empty ? IDLE : sel_q[rp_q[AW-1:0]] ? USR : PT;
      first_d   = done ? 1'b1 : rd ? 1'b0 : first_q;
      // sot must be set on exactly the first beat of each TLV
      err_d     = err_q || (rd && (beat.sot != first_q)) || (order_wen && !push);
      ob_d      = rd ? '{tvalid: 1'b1, tlast: beat.tlast, tid: beat.tid, tuser: beat.tuser,
                         tstrb: beat.tstrb, tdata: beat.tdata} : ob_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         wp_q    <= '0;
         rp_q    <= '0;
         first_q <= 1'b1;
         err_q   <= 1'b0;
         wr_q    <= 1'b0;
         ob_q    <= '0;
      end else begin
         state_q <= state_d;
         wp_q    <= wp_q + (AW+1)'(push);
         rp_q    <= rp_q + (AW+1)'(pop);
         first_q <= first_d;
         err_q   <= err_d;
         wr_q    <= rd;
         ob_q    <= ob_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push) sel_q[wp_q[AW-1:0]] <= order_sel;
   end
endmodule
